// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, NOP encoding, reset vector and
// fetch FSM states.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous-read
// instruction memory (slave); read data returns the cycle after the request.
interface fetch_stage_if;
  import mips_pkg::*;

  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry capture/bypass buffer: parks a response that arrives while decode is
// stalled and presents either the parked entry or the live response.
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            live_valid,
  input  logic [XLEN-1:0] live_instr,
  input  logic [XLEN-1:0] live_pc,
  input  logic            stall_D,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  // Depth 1 suffices: issue is suppressed while stall_D is high, so at most one
  // response can arrive during a stall.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (!stall_D) begin
      hold_valid_d = 1'b0;
      hold_instr_d = NOP;
      hold_pc_d    = '0;
    end else if (live_valid) begin
      hold_valid_d = 1'b1;
      hold_instr_d = live_instr;
      hold_pc_d    = live_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_comb begin
    valid = 1'b0;
    instr = NOP;
    pc    = '0;
    if (hold_valid_q) begin
      valid = 1'b1;
      instr = hold_instr_q;
      pc    = hold_pc_q;
    end else if (live_valid) begin
      valid = 1'b1;
      instr = live_instr;
      pc    = live_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues imem reads and presents the
// IF/ID register contents to decode, honouring stalls, redirects and halt.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_F,
  input  logic                 stall_D,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 halt_req,
  fetch_stage_if.master        imem,
  output logic [XLEN-1:0]      instr_D,
  output logic [XLEN-1:0]      pc_D,
  output logic [XLEN-1:0]      pc_plus4_D,
  output logic                 valid_D
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic issue;
  logic redir_take;
  logic halt_take;

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .live_valid (req_valid_q),
    .live_instr (imem.imem_rdata),
    .live_pc    (req_pc_q),
    .stall_D    (stall_D),
    .instr      (instr_D),
    .pc         (pc_D),
    .valid      (valid_D)
  );

  assign pc_plus4_D = pc_D + 32'd4;

  // Redirect and halt only act on a real instruction that decode is consuming.
  assign redir_take = redirect_valid & ~stall_D & valid_D;
  assign halt_take  = halt_req & ~stall_D & valid_D;
  assign issue      = (state_q == RUN) & ~stall_F & ~stall_D & ~halt_take;

  assign imem.imem_en   = issue;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_take) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Halt beats a simultaneous redirect, leaving the PC untouched.
  always_comb begin
    pc_d = pc_q;
    if (redir_take && !halt_take) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // The request issued alongside an accepted redirect is on the wrong path.
  assign req_valid_d = issue & ~redir_take;
  assign req_pc_d    = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage of the five-stage MIPS pipeline; sits directly upstream of decode.
- Owns the PC and issues requests to a synchronous-read instruction memory.
- Presents the IF/ID register contents (instruction, PC, PC+4, valid) to decode.
- Consumes stall_F/stall_D from the hazard unit and branch/jump redirects resolved in decode, and absorbs memory read latency with a one-entry hold buffer.

## Interface
- RESET_PC, 32'h0040_0000, address of first fetch after reset
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- stall_F  in  1  hold PC, issue nothing
- stall_D  in  1  hold IF/ID contents; internally also suppresses issue
- redirect_valid  in  1  decode resolved a taken branch/jump
- redirect_pc  in  32  target address, word-aligned
- halt_req  in  1  decode holds a halting instruction; stop fetching
- imem_en  out  1  read request this cycle
- imem_addr  out  32  read address
- imem_rdata  in  32  read data, valid the cycle after imem_en
- instr_D  out  32  instruction to decode; 32'h0 (NOP) when not valid
- pc_D  out  32  PC of instr_D
- pc_plus4_D  out  32  pc_D + 4, modulo 2^32
- valid_D  out  1  instr_D is a real instruction

## Operation
- States:
  - BOOT: first cycle after reset release, no issue; goes to RUN unconditionally.
  - RUN: normal fetch.
  - HALT: no issue; exited only by reset.
- issue = (state==RUN) & ~stall_F & ~stall_D & ~halt_take.
  - imem_en = issue.
  - imem_addr = pc_F.
- pc_F update:
  - On accepted redirect: pc_F <= redirect_pc.
  - Else if issue: pc_F <= pc_F + 4, wrapping modulo 2^32.
  - Else pc_F holds.
- Request tracking: req_valid_q <= issue & ~redir_take; req_pc_q <= pc_F.
- Live response exists when req_valid_q=1; imem_rdata carries it that cycle.
- Hold buffer captures hold_instr/hold_pc when a live response arrives and stall_D=1.
  - Cleared on any cycle with stall_D=0.
  - Depth 1 is sufficient because issue is suppressed while stall_D=1.
- D outputs:
  - Hold valid: take instr/pc from the hold buffer.
  - Else req_valid_q: take imem_rdata/req_pc_q.
  - Else valid_D=0, instr_D=0, pc_D=0.
- redir_take = redirect_valid & ~stall_D & valid_D.
  - Ignored while stall_D=1 or while valid_D=0.
  - The request issued in the same cycle (wrong path) is squashed.
- halt_take = halt_req & ~stall_D & valid_D: state <= HALT; no request issued that cycle.
- Simultaneous redirect and halt: halt wins and pc_F is not updated.
- Misaligned redirect_pc: low 2 bits are forced to 0.

## Timing
- Reset values:
  - pc_F=RESET_PC, state=BOOT.
  - req_valid_q=0, req_pc_q=0.
  - hold valid/instr/pc = 0.
  - imem_en=0, valid_D=0, instr_D=0, pc_D=0, pc_plus4_D=4.
- Fetch latency: request at cycle t appears on D outputs at t+1.
- Sustained throughput: 1 instruction/cycle.
- Redirect penalty: one bubble.
  - Redirect accepted at t: valid_D=0 at t+1, target on D at t+2.
- Stall: D outputs are stable for every stalled cycle.
  - On release at r, the held instruction is consumed at r and its successor appears at r+1.
  - No instruction is lost or duplicated.
- Reset mid-operation: all state clears immediately; an in-flight response is discarded.
  - Fetch resumes from RESET_PC via BOOT.

## Structure
- Shared package mips_pkg holds:
  - XLEN=32, NOP=32'h0, default reset vector.
  - fetch_state_t enum {BOOT, RUN, HALT}.
- One sub-module, fetch_hold_buf: one-entry capture/bypass buffer for instr+pc.
  - Inputs: live response, stall_D.
  - Outputs: selected instr/pc/valid.
- The top level contains the FSM, PC register and request tracking.

## Test plan
- Reset release, RESET_PC=0x0040_0000:
  - BOOT cycle imem_en=0.
  - Next cycle imem_addr=0x0040_0000.
  - Following cycle valid_D=1, pc_D=0x0040_0000, pc_plus4_D=0x0040_0004, then sequential +4 every cycle.
- stall_F=stall_D=1 for 3 cycles while D shows 0x0040_0008:
  - instr_D/pc_D constant, imem_en=0.
  - On release D shows 0x0040_0008 once, then 0x0040_000C.
- redirect_valid=1, redirect_pc=0x0040_0100 while D shows 0x0040_000C:
  - Next cycle valid_D=0, instr_D=0.
  - Cycle after that pc_D=0x0040_0100.
- redirect_valid=1 with stall_D=1: ignored; pc sequence unchanged after release.
- halt_req accepted at pc_D=0x0040_0010:
  - imem_en=0 forever and valid_D=0 from the next cycle.
  - Recovers only after rst_n pulse.
- rst_n asserted mid-stall with hold buffer valid:
  - Outputs reach reset values without a clock edge.
  - After release, fetch restarts at RESET_PC.
